unidade_controle: RTL
=====================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameters: none; all widths SHALL be fixed.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state inicial immediately.
REQ-004 iniciar  input  1  level request to start or restart a round.
REQ-005 fimC  input  1  address counter at last position (rco from datapath).
REQ-006 jogada  input  1  one-cycle pulse: player entered a move (jogada_feita).
REQ-007 igual  input  1  registered keys equal memory word (chavesIgualMemoria).
REQ-008 timeout  input  1  datapath timeout counter reached its end.
REQ-009 zeraC  output  1  synchronous clear of address counter.
REQ-010 contaC  output  1  increment address counter.
REQ-011 zeraR  output  1  clear key register and timeout counter.
REQ-012 registraR  output  1  load key register; restart timeout counter.
REQ-013 pronto  output  1  round finished.
REQ-014 acertou  output  1  round finished, all moves correct.
REQ-015 errou  output  1  round finished by wrong move or timeout.
REQ-016 db_timeout  output  1  round finished by timeout.
REQ-017 db_estado  output  4  current state code, for 7-segment debug.

Function
REQ-018 The block SHALL be a Moore FSM; every output SHALL be a function of the current state only.
REQ-019 State codes: inicial=0x0, preparacao=0x1, espera=0x2, registra=0x4, comparacao=0x5, proximo=0x6, fim_acerto=0xA, fim_erro=0xE, fim_timeout=0xD.
REQ-020 inicial: all control outputs 0; iniciar=1 -> preparacao; else stay.
REQ-021 preparacao: zeraC=1, zeraR=1 for exactly one cycle; unconditionally -> espera.
REQ-022 espera: all control outputs 0; jogada=1 -> registra; else timeout=1 -> fim_timeout; else stay.
REQ-023 Simultaneous jogada=1 and timeout=1 in espera SHALL go to registra (move has priority).
REQ-024 registra: registraR=1 for exactly one cycle; -> comparacao.
REQ-025 comparacao: igual=0 -> fim_erro; igual=1 and fimC=1 -> fim_acerto; igual=1 and fimC=0 -> proximo.
REQ-026 proximo: contaC=1 for exactly one cycle; -> espera.
REQ-027 fim_acerto: pronto=1, acertou=1; fim_erro: pronto=1, errou=1; fim_timeout: pronto=1, errou=1, db_timeout=1.
REQ-028 In any fim_* state, iniciar=1 -> preparacao (new round, counter re-cleared); else stay.
REQ-029 iniciar, jogada and timeout SHALL be ignored in preparacao, registra, comparacao and proximo.
REQ-030 Latency: jogada pulse in espera to registraR=1 is 1 cycle; to result decision is 2 cycles; to contaC or pronto is 3 cycles.
REQ-031 Any unused state code SHALL transition to inicial on the next edge with all outputs 0.
REQ-032 db_estado SHALL equal the state code of REQ-019 every cycle.

Reset
REQ-033 reset=1 SHALL asynchronously force inicial, with all control outputs 0 and db_estado=0x0, regardless of clock.
REQ-034 Reset asserted mid-round (any state) SHALL abort the round; after release, the block SHALL wait in inicial for iniciar.
REQ-035 No output SHALL pulse on the first edge after reset release unless iniciar=1.

Verification
REQ-036 Reset during proximo -> db_estado=0x0 before next edge, contaC=0; release with iniciar=0 for 5 cycles -> stays 0x0.
REQ-037 iniciar=1, then 16 jogada pulses with igual=1 and fimC=1 on the 16th -> db_estado ends 0xA, pronto=1, acertou=1; contaC pulsed 15 times.
REQ-038 iniciar, one correct move (fimC=0), second move igual=0 -> states 1,2,4,5,6,2,4,5,E; errou=1, acertou=0.
REQ-039 In espera, timeout=1 with jogada=0 -> next state 0xD, errou=1, db_timeout=1; same cycle with jogada=1 -> 0x4.
REQ-040 From 0xE, iniciar=1 -> 0x1 with zeraC=1 and zeraR=1 for one cycle, then 0x2.
REQ-041 jogada and iniciar pulsed while in comparacao with igual=1, fimC=0 -> next state 0x6 only; no extra registraR.

Source files
------------

// File: rtl/unidade_controle.sv
// unidade_controle: Moore control FSM for a memory-matching game round (moves, compare, timeout)
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimC,
    input  logic       jogada,
    input  logic       igual,
    input  logic       timeout,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        inicial     = 4'h0,
        preparacao  = 4'h1,
        espera      = 4'h2,
        registra    = 4'h4,
        comparacao  = 4'h5,
        proximo     = 4'h6,
        fim_acerto  = 4'hA,
        fim_timeout = 4'hD,
        fim_erro    = 4'hE
    } estado_t;

    estado_t estado, estado_prox;

    // state register; reset aborts any round immediately
    always_ff @(posedge clock or posedge reset)
        if (reset) estado <= inicial;
        else estado <= estado_prox;

    // next-state logic; a move beats a simultaneous timeout, unused codes fall back to inicial
    always_comb begin
        estado_prox = inicial;
        case (estado)
            inicial:     estado_prox = iniciar ? preparacao : inicial;
            preparacao:  estado_prox = espera;
            espera:      estado_prox = jogada ? registra : (timeout ? fim_timeout : espera);
            registra:    estado_prox = comparacao;
            comparacao:  estado_prox = !igual ? fim_erro : (fimC ? fim_acerto : proximo);
            proximo:     estado_prox = espera;
            fim_acerto:  estado_prox = iniciar ? preparacao : fim_acerto;
            fim_erro:    estado_prox = iniciar ? preparacao : fim_erro;
            fim_timeout: estado_prox = iniciar ? preparacao : fim_timeout;
            default:     estado_prox = inicial;
        endcase
    end

    assign zeraC      = estado == preparacao;
    assign zeraR      = estado == preparacao;
    assign registraR  = estado == registra;
    assign contaC     = estado == proximo;
    assign pronto     = estado == fim_acerto || estado == fim_erro || estado == fim_timeout;
    assign acertou    = estado == fim_acerto;
    assign errou      = estado == fim_erro || estado == fim_timeout;
    assign db_timeout = estado == fim_timeout;
    assign db_estado  = estado;
endmodule
